// File: rtl/cpu_pkg.sv
// Shared pipeline definitions: forward-mux encodings and the EX hold FSM states.
package cpu_pkg;
    localparam logic [1:0] FWD_NONE = 2'b00;
    localparam logic [1:0] FWD_WB   = 2'b01;
    localparam logic [1:0] FWD_MEM  = 2'b10;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;
endpackage

// File: rtl/hazard_ctrl_unit_if.sv
// Bundle between the pipeline datapath (master) and the hazard unit (slave).
interface hazard_ctrl_unit_if #(
    parameter int REG_AW  = 5,
    parameter int NUM_SRC = 2,
    parameter int CNT_W   = 16
);
    logic                        ID_Valid_i;
    logic [NUM_SRC*REG_AW-1:0]   ID_Rs_i;
    logic                        ID_Flush_i;
    logic                        EX_MemRead_i;
    logic                        EX_RegWrite_i;
    logic [REG_AW-1:0]           EX_Rd_i;
    logic                        EX_MulStart_i;
    logic                        MEM_RegWrite_i;
    logic [REG_AW-1:0]           MEM_Rd_i;
    logic                        WB_RegWrite_i;
    logic [REG_AW-1:0]           WB_Rd_i;
    logic [NUM_SRC*2-1:0]        Forward_o;
    logic                        PC_Write_o;
    logic                        IFID_Write_o;
    logic                        IFID_Flush_o;
    logic                        IDEX_Bubble_o;
    logic                        IDEX_Hold_o;
    logic                        EXMEM_Bubble_o;
    logic [CNT_W-1:0]            Stall_Cnt_o;

    modport master (
        output ID_Valid_i, ID_Rs_i, ID_Flush_i, EX_MemRead_i, EX_RegWrite_i, EX_Rd_i,
               EX_MulStart_i, MEM_RegWrite_i, MEM_Rd_i, WB_RegWrite_i, WB_Rd_i,
        input  Forward_o, PC_Write_o, IFID_Write_o, IFID_Flush_o, IDEX_Bubble_o,
               IDEX_Hold_o, EXMEM_Bubble_o, Stall_Cnt_o
    );

    modport slave (
        input  ID_Valid_i, ID_Rs_i, ID_Flush_i, EX_MemRead_i, EX_RegWrite_i, EX_Rd_i,
               EX_MulStart_i, MEM_RegWrite_i, MEM_Rd_i, WB_RegWrite_i, WB_Rd_i,
        output Forward_o, PC_Write_o, IFID_Write_o, IFID_Flush_o, IDEX_Bubble_o,
               IDEX_Hold_o, EXMEM_Bubble_o, Stall_Cnt_o
    );
endinterface

// File: rtl/hazard_ctrl_unit_fwd_sel.sv
// Forward-mux select for one EX source operand; MEM result is newer than WB.
module fwd_sel
    import cpu_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] rs_i,
    input  logic              mem_regwrite_i,
    input  logic [REG_AW-1:0] mem_rd_i,
    input  logic              wb_regwrite_i,
    input  logic [REG_AW-1:0] wb_rd_i,
    output logic [1:0]        fwd_o
);
    always_comb begin
        fwd_o = FWD_NONE;
        if (mem_regwrite_i && (mem_rd_i != '0) && (mem_rd_i == rs_i)) begin
            fwd_o = FWD_MEM;
        end else if (wb_regwrite_i && (wb_rd_i != '0) && (wb_rd_i == rs_i)) begin
            fwd_o = FWD_WB;
        end
    end
endmodule

// File: rtl/hazard_ctrl_unit.sv
// EX-stage hazard control: operand forwarding, load-use stall, multi-cycle EX hold
// and a saturating count of cycles in which the PC was frozen.
module hazard_ctrl_unit
    import cpu_pkg::*;
#(
    parameter int REG_AW  = 5,
    parameter int NUM_SRC = 2,
    parameter int MUL_LAT = 3,
    parameter int CNT_W   = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    hazard_ctrl_unit_if.slave  bus
);
    localparam int                BUSY_W    = (MUL_LAT > 2) ? $clog2(MUL_LAT - 1) : 1;
    localparam logic [BUSY_W-1:0] BUSY_LOAD = BUSY_W'((MUL_LAT > 2) ? MUL_LAT - 2 : 0);
    localparam logic              MUL_EN    = (MUL_LAT > 1);

    state_e                     state_q, state_d;
    logic [BUSY_W-1:0]          busy_cnt_q, busy_cnt_d;
    logic [NUM_SRC*REG_AW-1:0]  ex_rs_q, ex_rs_d;
    logic [CNT_W-1:0]           stall_cnt_q, stall_cnt_d;

    logic [NUM_SRC-1:0]         rs_hit;
    logic [NUM_SRC*2-1:0]       fwd;
    logic                       mul_start, hold, lu, pc_write;

    generate
        for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
            assign rs_hit[gi] = (bus.ID_Rs_i[gi*REG_AW +: REG_AW] == bus.EX_Rd_i);

            fwd_sel #(.REG_AW(REG_AW)) u_fwd_sel (
                .rs_i           (ex_rs_q[gi*REG_AW +: REG_AW]),
                .mem_regwrite_i (bus.MEM_RegWrite_i),
                .mem_rd_i       (bus.MEM_Rd_i),
                .wb_regwrite_i  (bus.WB_RegWrite_i),
                .wb_rd_i        (bus.WB_Rd_i),
                .fwd_o          (fwd[gi*2 +: 2])
            );
        end
    endgenerate

    // Reset gates the combinational requests so outputs fall back at once on async reset.
    assign mul_start = MUL_EN && rst_i && (state_q == IDLE) && bus.EX_MulStart_i;
    assign hold      = mul_start || ((state_q == BUSY) && (busy_cnt_q != '0));
    assign lu        = rst_i && (state_q == IDLE) && !mul_start && bus.ID_Valid_i &&
                       bus.EX_MemRead_i && bus.EX_RegWrite_i && (bus.EX_Rd_i != '0) && (|rs_hit);
    assign pc_write  = !(hold || lu);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= IDLE;
            busy_cnt_q  <= '0;
            ex_rs_q     <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            busy_cnt_q  <= busy_cnt_d;
            ex_rs_q     <= ex_rs_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Counter value 0 in BUSY is the release cycle: hold is already down there.
    always_comb begin
        state_d    = state_q;
        busy_cnt_d = busy_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (mul_start) begin
                    state_d    = BUSY;
                    busy_cnt_d = BUSY_LOAD;
                end
            end
            BUSY: begin
                if (busy_cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    busy_cnt_d = busy_cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ex_rs_d = bus.ID_Rs_i;
        if (hold) begin
            ex_rs_d = ex_rs_q;
        end else if (lu || !bus.ID_Valid_i) begin
            ex_rs_d = '0;
        end

        stall_cnt_d = stall_cnt_q;
        if (!pc_write && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_comb begin
        bus.Forward_o      = fwd;
        bus.PC_Write_o     = pc_write;
        bus.IFID_Write_o   = pc_write;
        bus.IFID_Flush_o   = bus.ID_Flush_i && !lu && !hold;
        bus.IDEX_Bubble_o  = lu;
        bus.IDEX_Hold_o    = hold;
        bus.EXMEM_Bubble_o = hold;
        bus.Stall_Cnt_o    = stall_cnt_q;
    end
endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Directed bench: four hazard units (MUL_LAT 3/1/4, and a 2-bit counter) share one stimulus.
module tb_hazard_ctrl_unit;
    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       id_valid, id_flush, ex_memread, ex_regwrite, ex_mulstart;
    logic       mem_regwrite, wb_regwrite;
    logic [9:0] id_rs;
    logic [4:0] ex_rd, mem_rd, wb_rd;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk_i = ~clk_i;

    hazard_ctrl_unit_if #(.REG_AW(5), .NUM_SRC(2), .CNT_W(16)) if3 ();
    hazard_ctrl_unit_if #(.REG_AW(5), .NUM_SRC(2), .CNT_W(16)) if1 ();
    hazard_ctrl_unit_if #(.REG_AW(5), .NUM_SRC(2), .CNT_W(16)) if4 ();
    hazard_ctrl_unit_if #(.REG_AW(5), .NUM_SRC(2), .CNT_W(2))  ifs ();

    assign {if3.ID_Valid_i, if3.ID_Rs_i, if3.ID_Flush_i, if3.EX_MemRead_i, if3.EX_RegWrite_i,
            if3.EX_Rd_i, if3.EX_MulStart_i, if3.MEM_RegWrite_i, if3.MEM_Rd_i, if3.WB_RegWrite_i,
            if3.WB_Rd_i} = {id_valid, id_rs, id_flush, ex_memread, ex_regwrite, ex_rd,
                            ex_mulstart, mem_regwrite, mem_rd, wb_regwrite, wb_rd};
    assign {if1.ID_Valid_i, if1.ID_Rs_i, if1.ID_Flush_i, if1.EX_MemRead_i, if1.EX_RegWrite_i,
            if1.EX_Rd_i, if1.EX_MulStart_i, if1.MEM_RegWrite_i, if1.MEM_Rd_i, if1.WB_RegWrite_i,
            if1.WB_Rd_i} = {id_valid, id_rs, id_flush, ex_memread, ex_regwrite, ex_rd,
                            ex_mulstart, mem_regwrite, mem_rd, wb_regwrite, wb_rd};
    assign {if4.ID_Valid_i, if4.ID_Rs_i, if4.ID_Flush_i, if4.EX_MemRead_i, if4.EX_RegWrite_i,
            if4.EX_Rd_i, if4.EX_MulStart_i, if4.MEM_RegWrite_i, if4.MEM_Rd_i, if4.WB_RegWrite_i,
            if4.WB_Rd_i} = {id_valid, id_rs, id_flush, ex_memread, ex_regwrite, ex_rd,
                            ex_mulstart, mem_regwrite, mem_rd, wb_regwrite, wb_rd};
    assign {ifs.ID_Valid_i, ifs.ID_Rs_i, ifs.ID_Flush_i, ifs.EX_MemRead_i, ifs.EX_RegWrite_i,
            ifs.EX_Rd_i, ifs.EX_MulStart_i, ifs.MEM_RegWrite_i, ifs.MEM_Rd_i, ifs.WB_RegWrite_i,
            ifs.WB_Rd_i} = {id_valid, id_rs, id_flush, ex_memread, ex_regwrite, ex_rd,
                            ex_mulstart, mem_regwrite, mem_rd, wb_regwrite, wb_rd};

    hazard_ctrl_unit #(.REG_AW(5), .NUM_SRC(2), .MUL_LAT(3), .CNT_W(16)) u3 (
        .clk_i(clk_i), .rst_i(rst_i), .bus(if3));
    hazard_ctrl_unit #(.REG_AW(5), .NUM_SRC(2), .MUL_LAT(1), .CNT_W(16)) u1 (
        .clk_i(clk_i), .rst_i(rst_i), .bus(if1));
    hazard_ctrl_unit #(.REG_AW(5), .NUM_SRC(2), .MUL_LAT(4), .CNT_W(16)) u4 (
        .clk_i(clk_i), .rst_i(rst_i), .bus(if4));
    hazard_ctrl_unit #(.REG_AW(5), .NUM_SRC(2), .MUL_LAT(3), .CNT_W(2))  us (
        .clk_i(clk_i), .rst_i(rst_i), .bus(ifs));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end else begin
            $display("ok   %s: 0x%0h", tag, obs);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic clr_in();
        id_valid = 1'b0; id_rs = '0; id_flush = 1'b0;
        ex_memread = 1'b0; ex_regwrite = 1'b0; ex_rd = '0; ex_mulstart = 1'b0;
        mem_regwrite = 1'b0; mem_rd = '0; wb_regwrite = 1'b0; wb_rd = '0;
    endtask

    task automatic set_lu();
        id_valid = 1'b1; id_rs = {5'd7, 5'd3};
        ex_memread = 1'b1; ex_regwrite = 1'b1; ex_rd = 5'd7;
    endtask

    initial begin
        clr_in();
        #2 rst_i = 1'b0;
        tick(); tick();
        check("rst_fwd",      32'(if3.Forward_o), 32'h0);
        check("rst_pcw",      32'(if3.PC_Write_o), 32'h1);
        check("rst_ifidw",    32'(if3.IFID_Write_o), 32'h1);
        check("rst_bubble",   32'(if3.IDEX_Bubble_o), 32'h0);
        check("rst_hold",     32'(if3.IDEX_Hold_o), 32'h0);
        check("rst_stall",    32'(if3.Stall_Cnt_o), 32'h0);
        rst_i = 1'b1;

        // Operand 0 = x5, operand 1 = x6 land in the EX copies.
        id_valid = 1'b1; id_rs = {5'd6, 5'd5};
        tick();
        mem_regwrite = 1'b1; mem_rd = 5'd5; wb_regwrite = 1'b1; wb_rd = 5'd5; #1;
        check("fwd_mem_prio", 32'(if3.Forward_o), 32'h2);
        wb_rd = 5'd6; #1;
        check("fwd_mem_wb",   32'(if3.Forward_o), 32'h6);
        mem_regwrite = 1'b0; wb_rd = 5'd5; #1;
        check("fwd_wb_only",  32'(if3.Forward_o), 32'h1);
        mem_regwrite = 1'b1; mem_rd = 5'd6; #1;
        check("fwd_cross",    32'(if3.Forward_o), 32'h9);

        id_rs = '0;
        tick();
        mem_rd = 5'd0; wb_rd = 5'd0; #1;
        check("fwd_x0",       32'(if3.Forward_o), 32'h0);

        id_valid = 1'b0; id_rs = {5'd6, 5'd5};
        tick();
        mem_rd = 5'd5; wb_rd = 5'd6; #1;
        check("fwd_invalid",  32'(if3.Forward_o), 32'h0);

        // Load-use with a simultaneous branch flush request.
        clr_in(); set_lu(); id_flush = 1'b1; #1;
        check("lu_pcw",       32'(if3.PC_Write_o), 32'h0);
        check("lu_ifidw",     32'(if3.IFID_Write_o), 32'h0);
        check("lu_bubble",    32'(if3.IDEX_Bubble_o), 32'h1);
        check("lu_flush",     32'(if3.IFID_Flush_o), 32'h0);
        tick();
        ex_memread = 1'b0; ex_regwrite = 1'b0;
        mem_regwrite = 1'b1; mem_rd = 5'd3; wb_regwrite = 1'b1; wb_rd = 5'd7; #1;
        check("lu_stall_cnt", 32'(if3.Stall_Cnt_o), 32'h1);
        check("lu_rs_cleared", 32'(if3.Forward_o), 32'h0);
        check("lu_done_pcw",  32'(if3.PC_Write_o), 32'h1);
        check("flush_pass",   32'(if3.IFID_Flush_o), 32'h1);

        // Multi-cycle op; load-use inputs present in the start cycle must be masked.
        clr_in(); tick();
        set_lu(); ex_mulstart = 1'b1; #1;
        check("mul_hold0",    32'(if3.IDEX_Hold_o), 32'h1);
        check("mul_exmem0",   32'(if3.EXMEM_Bubble_o), 32'h1);
        check("mul_pcw0",     32'(if3.PC_Write_o), 32'h0);
        check("mul_lu_mask",  32'(if3.IDEX_Bubble_o), 32'h0);
        check("lat1_hold",    32'(if1.IDEX_Hold_o), 32'h0);
        check("lat1_lu",      32'(if1.IDEX_Bubble_o), 32'h1);
        tick();
        clr_in(); #1;
        check("mul_hold1",    32'(if3.IDEX_Hold_o), 32'h1);
        check("lat1_idle",    32'(if1.IDEX_Hold_o), 32'h0);
        check("lat4_hold1",   32'(if4.IDEX_Hold_o), 32'h1);
        tick(); #1;
        check("mul_release",  32'(if3.IDEX_Hold_o), 32'h0);
        check("mul_rel_pcw",  32'(if3.PC_Write_o), 32'h1);
        check("lat4_hold2",   32'(if4.IDEX_Hold_o), 32'h1);
        tick(); #1;
        check("lat4_release", 32'(if4.IDEX_Hold_o), 32'h0);
        check("mul_stall3",   32'(if3.Stall_Cnt_o), 32'h3);
        check("lat1_stall",   32'(if1.Stall_Cnt_o), 32'h2);
        check("lat4_stall",   32'(if4.Stall_Cnt_o), 32'h4);

        // Two more load-use stalls: 2-bit counter must stay pinned at 3.
        for (int i = 0; i < 2; i++) begin
            set_lu(); tick();
            clr_in(); tick();
        end
        #1;
        check("sat_cnt",      32'(ifs.Stall_Cnt_o), 32'h3);
        check("stall5",       32'(if3.Stall_Cnt_o), 32'h5);

        // Reset in the second BUSY cycle of the MUL_LAT=4 unit.
        ex_mulstart = 1'b1; tick();
        ex_mulstart = 1'b0; tick(); #1;
        check("busy2_hold",   32'(if4.IDEX_Hold_o), 32'h1);
        rst_i = 1'b0; #1;
        check("arst_hold",    32'(if4.IDEX_Hold_o), 32'h0);
        check("arst_exmem",   32'(if4.EXMEM_Bubble_o), 32'h0);
        check("arst_pcw",     32'(if4.PC_Write_o), 32'h1);
        check("arst_stall",   32'(if4.Stall_Cnt_o), 32'h0);
        tick();
        rst_i = 1'b1;
        tick(); tick(); #1;
        check("post_rst_hold",  32'(if4.IDEX_Hold_o), 32'h0);
        check("post_rst_stall", 32'(if4.Stall_Cnt_o), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
